blink_led_1_with_systemverilog: RTL and testbench
=================================================

// Module: blink_led_1_with_systemverilog
//
// PURPOSE
//  Free-running LED blinker for the MAX10 eval board top level.
//  Divides the 50 MHz board clock down to a square wave with 50 % duty on one LED pin.
//  Contains its own reset-release synchroniser, so a raw async board reset can drive it directly.
//
// PARAMETERS
//  CLK_FREQ_HZ      50_000_000  input clock frequency in Hz
//  BLINK_FREQ_HZ    1           LED toggle-pair frequency in Hz (full on+off period)
//  LED_RESET_LEVEL  1'b0        led level while in reset and right after release
//  localparam HALF_PERIOD_CYCLES = CLK_FREQ_HZ / (2*BLINK_FREQ_HZ)   (default 25_000_000)
//  localparam CNT_W = $clog2(HALF_PERIOD_CYCLES)
//
// PORTS
//  clk        input   1  system clock, 50 MHz, all logic on rising edge
//  rst_async  input   1  reset: asynchronous, active-high (async assert, synchronised release)
//  led        output  1  LED drive, registered
//
// BEHAVIOUR
//  - Elaboration: $error if HALF_PERIOD_CYCLES < 2 or BLINK_FREQ_HZ == 0.
//  - Reset sync: 2-flop chain, async-cleared by rst_async. Internal reset rst_i = ~ff2.
//    rst_i asserts immediately (no clock needed) and deasserts after 2 rising edges with rst_async low.
//  - While rst_i=1: cnt = 0, led = LED_RESET_LEVEL. Both clear asynchronously.
//  - Counter: cnt (CNT_W bits) increments by 1 each edge while rst_i=0.
//    At cnt == HALF_PERIOD_CYCLES-1 it wraps to 0 and led toggles on the same edge.
//    No other state. cnt never exceeds HALF_PERIOD_CYCLES-1.
//  - Timing: let E0 be the first rising edge with rst_async sampled low and N = HALF_PERIOD_CYCLES.
//    First led toggle is at edge E(N+1). Later toggles follow every N edges, so the period is 2N cycles.
//  - Reset mid-operation, at any cnt/led value: led returns to LED_RESET_LEVEL asynchronously.
//    Timing then restarts exactly as after power-up.
//  - A reset pulse shorter than one clock period still fully resets the block (async clear).
//  - No glitches on led: it is driven straight from a flop.
//
// STRUCTURE
//  - Package blink_pkg holds the default constants: CLK_FREQ_HZ_DEFAULT=50_000_000, BLINK_FREQ_HZ_DEFAULT=1.
//  - Sub-module rst_sync_2ff (ports clk, rst_async, rst_sync) implements the reset-release synchroniser.
//    It is reused by other top levels.
//  - Top file holds the counter and the led toggle flop.
//
// TESTING  (sim with CLK_FREQ_HZ=20, BLINK_FREQ_HZ=1 -> N=10; clk period 20 ns)
//  1. Assert rst_async at t=2.75 clk periods, hold 3 periods -> led=0 and cnt=0 for the whole interval.
//  2. Release reset -> led rises at E11 and falls at E21; high/low each 10 cycles, period 20 cycles.
//  3. Assert rst_async between edges while led=1 -> led=0 before the next clk edge.
//     Release -> first toggle at E11 again.
//  4. 5 ns rst_async glitch, with no clk edge inside it, at cnt=7 -> cnt=0, led=0.
//     Restart timing as in scenario 2.
//  5. Default params, 2.1 s sim -> led toggles every 25_000_000 cycles (0.5 s); cnt max = 24_999_999.
//  6. LED_RESET_LEVEL=1 -> led=1 in reset and first falls at E11; same periodicity.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared constants and helpers for the board-level LED blinkers.
package blink_pkg;

  localparam int CLK_FREQ_HZ_DEFAULT   = 50_000_000;
  localparam int BLINK_FREQ_HZ_DEFAULT = 1;

  // Clock cycles per led half period; a zero blink rate maps to a safe value.
  function automatic int half_period(input int clk_hz, input int blink_hz);
    if (blink_hz == 0)
      return 2;
    return clk_hz / (2 * blink_hz);
  endfunction

  function automatic int cnt_width(input int half);
    if (half <= 2)
      return 1;
    return $clog2(half);
  endfunction

endpackage

// File: rtl/rst_sync_2ff.sv
// Reset-release synchroniser: asserts at once, releases after two clocks.
module rst_sync_2ff (
  input  logic clk,
  input  logic rst_async,
  output logic rst_sync
);

  logic ff1;
  logic ff2;

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      ff1 <= 1'b0;
      ff2 <= 1'b0;
    end else begin
      ff1 <= 1'b1;
      ff2 <= ff1;
    end
  end

  assign rst_sync = ~ff2;

endmodule

// File: rtl/blink_led_1_with_systemverilog.sv
// Free-running 50 % duty LED blinker with its own reset-release synchroniser.
module blink_led_1_with_systemverilog
  import blink_pkg::*;
#(
  parameter int   CLK_FREQ_HZ     = CLK_FREQ_HZ_DEFAULT,
  parameter int   BLINK_FREQ_HZ   = BLINK_FREQ_HZ_DEFAULT,
  parameter logic LED_RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_async,
  output logic led
);

  localparam int HALF_PERIOD_CYCLES =
    half_period(CLK_FREQ_HZ, BLINK_FREQ_HZ);
  localparam int CNT_W = cnt_width(HALF_PERIOD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(HALF_PERIOD_CYCLES - 1);

  if (HALF_PERIOD_CYCLES < 2 || BLINK_FREQ_HZ == 0) begin : g_bad_param
    $error("blink: HALF_PERIOD_CYCLES < 2 or BLINK_FREQ_HZ == 0");
  end

  logic             rst_i;
  logic [CNT_W-1:0] cnt;
  logic             wrap;

  rst_sync_2ff u_rst_sync (
    .clk       (clk),
    .rst_async (rst_async),
    .rst_sync  (rst_i)
  );

  assign wrap = (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // led comes straight off this flop so the pin never glitches
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      led <= LED_RESET_LEVEL;
    end else if (wrap) begin
      led <= ~led;
    end
  end

endmodule

// File: tb/tb_blink_led_1_with_systemverilog.sv
// Bench for the LED blinker: edge-count model plus directed literal checks.
module tb_blink_led_1_with_systemverilog;

  localparam int N = 10;

  logic clk = 1'b0;
  logic rst_async = 1'b0;
  logic led0;
  logic led1;

  int checks = 0;
  int errors = 0;
  int k = -1;
  bit en = 1'b0;

  blink_led_1_with_systemverilog #(
    .CLK_FREQ_HZ     (20),
    .BLINK_FREQ_HZ   (1),
    .LED_RESET_LEVEL (1'b0)
  ) dut0 (
    .clk       (clk),
    .rst_async (rst_async),
    .led       (led0)
  );

  blink_led_1_with_systemverilog #(
    .CLK_FREQ_HZ     (20),
    .BLINK_FREQ_HZ   (1),
    .LED_RESET_LEVEL (1'b1)
  ) dut1 (
    .clk       (clk),
    .rst_async (rst_async),
    .led       (led1)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic act,
                       input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t",
               name, act, exp, $time);
    end
  endtask

  // k = edges since the first edge with reset low (E0); -1 while in reset.
  // Toggle count after edge Ek is floor((k-1)/N) for k >= 1.
  function automatic logic model(input logic lvl);
    if (rst_async || k < 1)
      return lvl;
    return lvl ^ logic'(((k - 1) / N) % 2);
  endfunction

  always @(posedge rst_async) k = -1;

  always @(posedge clk) begin
    if (rst_async)
      k = -1;
    else if (k < 1_000_000)
      k++;
  end

  always @(negedge clk) begin
    if (en) begin
      check("model_lvl0", led0, model(1'b0));
      check("model_lvl1", led1, model(1'b1));
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // power-up reset at 2.75 periods, held for 3 periods
    #55 rst_async = 1'b1;
    en = 1'b1;
    #2;
    check("rst_led0", led0, 1'b0);
    check("rst_led1", led1, 1'b1);
    #58 rst_async = 1'b0;

    // E0, then first toggle at E11, second at E21, third at E31
    edges(1);
    edges(10);
    check("e10_led0", led0, 1'b0);
    check("e10_led1", led1, 1'b1);
    edges(1);
    check("e11_led0", led0, 1'b1);
    check("e11_led1", led1, 1'b0);
    edges(9);
    check("e20_led0", led0, 1'b1);
    edges(1);
    check("e21_led0", led0, 1'b0);
    check("e21_led1", led1, 1'b1);
    edges(10);
    check("e31_led0", led0, 1'b1);

    // reset between edges while led is high
    #5 rst_async = 1'b1;
    #2;
    check("mid_rst_led0", led0, 1'b0);
    check("mid_rst_led1", led1, 1'b1);
    #20 rst_async = 1'b0;
    edges(1);
    edges(10);
    check("re_e10_led0", led0, 1'b0);
    edges(1);
    check("re_e11_led0", led0, 1'b1);
    check("re_e11_led1", led1, 1'b0);

    // short glitch with no clock edge inside, counter at 7
    edges(7);
    check("pre_glitch_led0", led0, 1'b1);
    #3 rst_async = 1'b1;
    #5 rst_async = 1'b0;
    #1;
    check("glitch_led0", led0, 1'b0);
    check("glitch_led1", led1, 1'b1);
    edges(1);
    edges(10);
    check("gl_e10_led0", led0, 1'b0);
    edges(1);
    check("gl_e11_led0", led0, 1'b1);
    edges(10);
    check("gl_e21_led0", led0, 1'b0);
    check("gl_e21_led1", led1, 1'b1);

    // free run across several full periods under the model
    edges(45);
    en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
